reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 5, register address width.
REQ-002 SHALL have parameter: DATA_W, 32, write data width.
REQ-003 SHALL have port: clk  input  1  single rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: req_valid  input  3  per-requester write request (bit0 rt-path, bit1 rd-path, bit2 link-path).
REQ-006 SHALL have port: req_ready  output  3  per-requester accept.
REQ-007 SHALL have ports: req_addr0/1/2  input  ADDR_W each  destination register per requester.
REQ-008 SHALL have ports: req_data0/1/2  input  DATA_W each  write data per requester.
REQ-009 SHALL have port: wr_en  output  1  register file write strobe.
REQ-010 SHALL have port: wr_sel  output  2  destination mux selector, 0=rt, 1=rd, 2=link, 3 never driven.
REQ-011 SHALL have ports: wr_addr (output, ADDR_W) and wr_data (output, DATA_W), the granted write.
REQ-012 SHALL have port: busy  output  1  any holding buffer occupied.

Function
REQ-013 SHALL hold one entry (valid, addr, data) per requester.
REQ-014 SHALL drive req_ready[i] high when buffer i is empty or is granted in the current cycle.
REQ-015 SHALL capture req_addr_i/req_data_i into buffer i on a rising edge with req_valid[i] and req_ready[i] both high.
REQ-016 SHALL grant at most one occupied buffer per cycle, round-robin starting from pointer rr_ptr (0..2).
REQ-017 SHALL set rr_ptr to (granted index + 1) mod 3 after each grant, and leave it unchanged when no grant occurs.
REQ-018 SHALL register the grant: wr_en, wr_sel=index, wr_addr and wr_data appear on the cycle after the grant cycle.
REQ-019 SHALL make an accepted request visible at wr_en no earlier than 2 cycles after acceptance (accept edge N, grant cycle N+1, write cycle N+2).
REQ-020 SHALL consume a granted entry whose addr is 0 but keep wr_en low; wr_sel, wr_addr and wr_data still update.
REQ-021 SHALL drive wr_en low on any cycle following a cycle with no grant; wr_sel, wr_addr and wr_data hold their last values.
REQ-022 SHALL allow accept and grant of the same buffer in the same cycle, giving back-to-back throughput of 1 per cycle for a single requester.
REQ-023 SHALL grant any occupied buffer within 3 cycles of its becoming occupied (no starvation).
REQ-024 SHALL drive busy as the OR of the three buffer valid bits.

Reset
REQ-025 SHALL on rst_n low, immediately and asynchronously, clear all buffer valid bits and set rr_ptr=0, wr_en=0, wr_sel=0, wr_addr=0 and wr_data=0.
REQ-026 SHALL discard pending entries on reset mid-operation, with no write issued for them after release.
REQ-027 SHALL hold req_ready=3'b111 while in reset and from the first edge after release.

Structure
REQ-028 SHALL take the selector encodings (SEL_RT=0, SEL_RD=1, SEL_LINK=2) and the default widths from the shared processor package.
REQ-029 SHALL place round-robin selection in one sub-module, rr_pick3 (inputs: 3-bit occupancy and rr_ptr; outputs: grant valid and 2-bit index).

Verification
REQ-030 SHALL cover single request: req_valid=3'b010, addr0x08, data0xDEADBEEF at edge 1 -> wr_en=1, wr_sel=1, wr_addr=8, wr_data=0xDEADBEEF in cycle 3.
REQ-031 SHALL cover simultaneous requests: all three valid in one cycle with addrs 1/2/31 -> writes in consecutive cycles with wr_sel 0,1,2; busy falls after the third grant.
REQ-032 SHALL cover fairness: requester 0 valid continuously, requester 2 valid once -> requester 2 written within 3 cycles and wr_sel sequence 0,2,0,...
REQ-033 SHALL cover the zero register: request on requester 1 with addr 0 -> buffer consumed, req_ready[1] returns high, wr_en stays 0.
REQ-034 SHALL cover streaming: requester 0 valid for 5 consecutive cycles with data 1..5 -> 5 consecutive writes of 1..5 and req_ready[0] continuously high.
REQ-035 SHALL cover reset mid-operation: rst_n low with all buffers full -> wr_en=0 and busy=0 immediately, and no write after release.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// ============================================================================
// reg_write_arbiter_pkg
// Shared selector encodings, default widths and round-robin index helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_write_arbiter_pkg;

  localparam int ADDR_W_DEFAULT = 5;
  localparam int DATA_W_DEFAULT = 32;

  localparam logic [1:0] SEL_RT   = 2'd0;
  localparam logic [1:0] SEL_RD   = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  // Modulo-3 addition of a requester index and an offset.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return rr_add(idx, 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick3.sv
// ============================================================================
// rr_pick3
// Picks the first occupied requester at or after rr_ptr, wrapping modulo 3.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick3
  import reg_write_arbiter_pkg::*;
(
  input  logic [2:0] occ,
  input  logic [1:0] rr_ptr,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);

  // Scan farthest offset first so the nearest occupied slot overrides.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = SEL_RT;
    for (int k = 2; k >= 0; k--) begin
      if (occ[rr_add(rr_ptr, 2'(k))]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_add(rr_ptr, 2'(k));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// reg_write_arbiter
// Three single-entry write buffers funnelled round-robin into one register port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  logic [2:0]        r_vld;
  logic [ADDR_W-1:0] r_addr [3];
  logic [DATA_W-1:0] r_data [3];
  logic [1:0]        r_ptr;

  logic              w_gnt_valid;
  logic [1:0]        w_gnt_idx;
  logic [2:0]        w_gnt_oh;
  logic [ADDR_W-1:0] w_req_addr [3];
  logic [DATA_W-1:0] w_req_data [3];

  assign w_req_addr[0] = req_addr0;
  assign w_req_addr[1] = req_addr1;
  assign w_req_addr[2] = req_addr2;
  assign w_req_data[0] = req_data0;
  assign w_req_data[1] = req_data1;
  assign w_req_data[2] = req_data2;

  rr_pick3 u_pick (
    .occ       (r_vld),
    .rr_ptr    (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_gnt_oh  = w_gnt_valid ? (3'b001 << w_gnt_idx) : 3'b000;
  // A buffer being drained this cycle can refill on the same edge.
  assign req_ready = ~r_vld | w_gnt_oh;
  assign busy      = |r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          r_vld[i]  <= 1'b1;
          r_addr[i] <= w_req_addr[i];
          r_data[i] <= w_req_data[i];
        end else if (w_gnt_oh[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Register zero is architecturally fixed: consume the entry, suppress the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= SEL_RT;
      wr_en   <= 1'b0;
      wr_sel  <= SEL_RT;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (w_gnt_valid) begin
      r_ptr   <= rr_next(w_gnt_idx);
      wr_en   <= |r_addr[w_gnt_idx];
      wr_sel  <= w_gnt_idx;
      wr_addr <= r_addr[w_gnt_idx];
      wr_data <= r_data[w_gnt_idx];
    end else begin
      wr_en <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// tb_reg_write_arbiter
// Directed scenarios plus random traffic against a cycle-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [AW-1:0] req_addr0, req_addr1, req_addr2;
  logic [DW-1:0] req_data0, req_data1, req_data2;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;

  int errors = 0;
  int checks = 0;

  reg_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending entries, pointer and the expected write port.
  logic          m_vld  [3];
  logic [AW-1:0] m_addr [3];
  logic [DW-1:0] m_data [3];
  int            m_ptr;
  logic          e_en;
  logic [1:0]    e_sel;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  function automatic int pick();
    for (int k = 0; k < 3; k++)
      if (m_vld[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    logic [2:0] r;
    int g = pick();
    for (int i = 0; i < 3; i++) r[i] = !m_vld[i] || (g == i);
    return r;
  endfunction

  function automatic logic exp_busy();
    return m_vld[0] || m_vld[1] || m_vld[2];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0; e_en = 1'b0; e_sel = 2'd0; e_addr = '0; e_data = '0;
  endtask

  // Drive one cycle of inputs, advance the model, land on the following negedge.
  task automatic cycle(input logic [2:0] v, input logic [AW-1:0] x0, x1, x2,
                       input logic [DW-1:0] y0, y1, y2);
    logic [2:0]    rdy;
    logic [AW-1:0] xa [3];
    logic [DW-1:0] ya [3];
    int g;
    req_valid = v;
    req_addr0 = x0; req_addr1 = x1; req_addr2 = x2;
    req_data0 = y0; req_data1 = y1; req_data2 = y2;
    xa[0] = x0; xa[1] = x1; xa[2] = x2;
    ya[0] = y0; ya[1] = y1; ya[2] = y2;
    rdy = exp_ready();
    g = pick();
    if (g >= 0) begin
      e_en = (m_addr[g] != 0); e_sel = 2'(g); e_addr = m_addr[g]; e_data = m_data[g];
      m_vld[g] = 1'b0;
      m_ptr = (g + 1) % 3;
    end else begin
      e_en = 1'b0;
    end
    for (int i = 0; i < 3; i++)
      if (v[i] && rdy[i]) begin
        m_vld[i] = 1'b1; m_addr[i] = xa[i]; m_data[i] = ya[i];
      end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(3'b000, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 3'b000;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, busy, wr_en, wr_sel, wr_addr, wr_data} !== {3'b111, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {req_ready, busy, wr_en, wr_sel, wr_addr, wr_data},
               {3'b111, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0});
    end
    rst_n = 1'b1;
    idle();
    checks++;
    if (req_ready !== 3'b111 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b wr_en=%b exp ready=111 wr_en=0", req_ready, wr_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    cycle(3'b010, 5'd0, 5'd8, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0);
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_accept wr_en=%b busy=%b exp 0/1", wr_en, busy);
    end
    idle();
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 2'd1, 5'd8, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_write got=%h exp=%h", {wr_en, wr_sel, wr_addr, wr_data}, {1'b1, 2'd1, 5'd8, 32'hDEADBEEF});
    end
    idle();
    checks++;
    if (wr_en !== 1'b0 || wr_sel !== 2'd1 || wr_data !== 32'hDEADBEEF || busy !== 1'b0) begin
      errors++; $display("FAIL single_hold wr_en=%b sel=%0d data=%h busy=%b", wr_en, wr_sel, wr_data, busy);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] sels [3];
    logic       bsy  [3];
    logic [2:0] ens;
    do_reset();
    cycle(3'b111, 5'd1, 5'd2, 5'd31, 32'h11, 32'h22, 32'h33);
    for (int j = 0; j < 3; j++) begin
      idle();
      sels[j] = wr_sel; bsy[j] = busy; ens[j] = wr_en;
    end
    checks++;
    if (ens !== 3'b111 || sels[0] !== 2'd0 || sels[1] !== 2'd1 || sels[2] !== 2'd2) begin
      errors++; $display("FAIL simul_order en=%b sel=%0d,%0d,%0d exp en=111 sel=0,1,2", ens, sels[0], sels[1], sels[2]);
    end
    checks++;
    if (bsy[1] !== 1'b1 || bsy[2] !== 1'b0) begin
      errors++; $display("FAIL simul_busy busy=%b,%b exp 1,0", bsy[1], bsy[2]);
    end
    checks++;
    if (wr_addr !== 5'd31 || wr_data !== 32'h33) begin
      errors++; $display("FAIL simul_last addr=%0d data=%h exp 31/33", wr_addr, wr_data);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] q [$];
    int first2 = -1;
    do_reset();
    cycle(3'b101, 5'd3, 5'd0, 5'd7, 32'd100, 32'd0, 32'd200);
    for (int c = 0; c < 6; c++) begin
      cycle(3'b001, 5'd3, 5'd0, 5'd0, 32'(101 + c), 32'd0, 32'd0);
      if (wr_en) begin
        q.push_back(wr_sel);
        if (wr_sel == 2'd2 && first2 < 0) first2 = c;
      end
    end
    checks++;
    if (q.size() < 3) begin
      errors++; $display("FAIL fair_count writes=%0d exp>=3", q.size());
    end else if (q[0] !== 2'd0 || q[1] !== 2'd2 || q[2] !== 2'd0) begin
      errors++; $display("FAIL fair_order sel=%0d,%0d,%0d exp 0,2,0", q[0], q[1], q[2]);
    end
    checks++;
    if (first2 < 0 || first2 > 2) begin
      errors++; $display("FAIL fair_latency link write at cycle %0d exp <=2", first2);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    cycle(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h55, 32'd0);
    idle();
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b0, 2'd1, 5'd0, 32'h55}) begin
      errors++; $display("FAIL zero_reg got=%h exp=%h", {wr_en, wr_sel, wr_addr, wr_data}, {1'b0, 2'd1, 5'd0, 32'h55});
    end
    checks++;
    if (req_ready !== 3'b111 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_consume ready=%b busy=%b exp 111/0", req_ready, busy);
    end
    idle();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++; $display("FAIL zero_after wr_en=%b exp 0", wr_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs;
    logic [2:0] rdy_ok;
    logic [DW-1:0] dq [$];
    rdy_ok = 3'b111;
    do_reset();
    for (int j = 0; j < 7; j++) begin
      if (j < 5) begin
        if (req_ready[0] !== 1'b1) rdy_ok = 3'b000;
        cycle(3'b001, 5'd4, 5'd0, 5'd0, 32'(j + 1), 32'd0, 32'd0);
      end else begin
        idle();
      end
      obs[j] = wr_en;
      if (wr_en) dq.push_back(wr_data);
    end
    checks++;
    if (rdy_ok !== 3'b111) begin
      errors++; $display("FAIL stream_ready ready0 dropped, exp continuously 1");
    end
    checks++;
    if (obs !== 7'b0111110) begin
      errors++; $display("FAIL stream_strobe got=%b exp=0111110", obs);
    end
    checks++;
    if (dq.size() != 5 || dq[0] !== 32'd1 || dq[1] !== 32'd2 || dq[2] !== 32'd3 ||
        dq[3] !== 32'd4 || dq[4] !== 32'd5) begin
      errors++; $display("FAIL stream_data count=%0d exp 5 writes of 1..5", dq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ens;
    do_reset();
    cycle(3'b111, 5'd9, 5'd10, 5'd11, 32'hA, 32'hB, 32'hC);
    req_valid = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, busy, req_ready} !== {1'b0, 1'b0, 3'b111}) begin
      errors++; $display("FAIL midreset_async got=%b exp=00111", {wr_en, busy, req_ready});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      idle();
      ens[j] = wr_en | busy;
    end
    checks++;
    if (ens !== 4'b0000) begin
      errors++; $display("FAIL midreset_nowrite en|busy=%b exp 0000", ens);
    end
  endtask

  task automatic test_random();
    logic [2:0]    v;
    logic [AW-1:0] x0, x1, x2;
    for (int n = 0; n < 400; n++) begin
      v  = 3'($urandom_range(0, 7));
      x0 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      x1 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      x2 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      cycle(v, x0, x1, x2, $urandom, $urandom, $urandom);
      checks++;
      if ({req_ready, busy, wr_en, wr_sel, wr_addr, wr_data} !==
          {exp_ready(), exp_busy(), e_en, e_sel, e_addr, e_data}) begin
        errors++;
        $display("FAIL random_cycle n=%0d got=%h exp=%h", n,
                 {req_ready, busy, wr_en, wr_sel, wr_addr, wr_data},
                 {exp_ready(), exp_busy(), e_en, e_sel, e_addr, e_data});
      end
    end
  endtask

  initial begin
    req_valid = 3'b000;
    req_addr0 = '0; req_addr1 = '0; req_addr2 = '0;
    req_data0 = '0; req_data1 = '0; req_data2 = '0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
